// File: rtl/imm_narrow.sv
// imm_narrow: packs a W-bit signed value into an N-bit signed immediate field.
// The result is flagged as fitting when sign-extending the N-bit field back to
// W bits reproduces the input exactly. Two-stage valid/ready pipeline with
// overflow statistics.
//
// Optional feature (compile-time macro IMM_NARROW_SATURATE_EN):
//   defined   - a non-fitting value clamps to the N-bit extreme of its sign
//   undefined - a non-fitting value is truncated to its low N bits
// The fit flag and the statistics are identical in both builds.
module imm_narrow #(
    parameter int N     = 7,
    parameter int W     = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_data,
    output logic             out_fit,
    output logic [CNT_W-1:0] ovf_count,
    output logic             ovf_sticky,
    input  logic             clr_stats
);

    // Bits that must all agree for the value to be representable: the N-1th
    // bit (sign of the narrow field) up to the top bit of the wide value.
    localparam int HI_W = W - N + 1;

    // ------------------------------------------------------------------
    // Representability check on the incoming word
    // ------------------------------------------------------------------
    logic [HI_W-1:0] upper_bits;
    logic            in_fit;

    generate
        for (genvar gi = 0; gi < HI_W; gi++) begin : g_upper
            assign upper_bits[gi] = in_data[N-1+gi];
        end
    endgenerate

    // All ones or all zeros means sign-extension round-trips exactly.
    assign in_fit = (&upper_bits) | ~(|upper_bits);

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    // S1 keeps only what S2 needs: the low N bits, the fit flag and (for the
    // clamping build) the sign of the wide value. The discarded middle bits
    // carry no information once the fit flag has been computed.
    logic             s1_valid_reg;
    logic [N-1:0]     s1_low_reg;
    logic             s1_fit_reg;
`ifdef IMM_NARROW_SATURATE_EN
    logic             s1_neg_reg;
`endif

    logic             s2_valid_reg;
    logic [N-1:0]     s2_data_reg;
    logic             s2_fit_reg;

    logic [CNT_W-1:0] ovf_count_reg;
    logic [CNT_W-1:0] ovf_count_next;
    logic             ovf_sticky_reg;
    logic             ovf_sticky_next;

    logic             s1_take;
    logic             s2_take;
    logic             in_xfer;
    logic             out_xfer;
    logic [N-1:0]     narrow_next;

    // ------------------------------------------------------------------
    // Handshake / advance conditions
    // ------------------------------------------------------------------
    // A stage may load when it is empty or its contents move on this cycle.
    assign s2_take  = ~s2_valid_reg | out_ready;
    assign s1_take  = ~s1_valid_reg | s2_take;
    assign in_ready = s1_take;
    assign in_xfer  = in_valid & s1_take;
    assign out_xfer = s2_valid_reg & out_ready;

    // ------------------------------------------------------------------
    // Narrowing of the S1 word into the N-bit field
    // ------------------------------------------------------------------
`ifdef IMM_NARROW_SATURATE_EN
    localparam logic [N-1:0] SAT_POS = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] SAT_NEG = {1'b1, {(N-1){1'b0}}};

    // Fitting words pass through; out-of-range words clamp by sign.
    always_comb begin
        narrow_next = s1_low_reg;
        if (!s1_fit_reg) begin
            narrow_next = s1_neg_reg ? SAT_NEG : SAT_POS;
        end
    end
`else
    // Plain truncation: the low N bits are the field.
    always_comb begin
        narrow_next = s1_low_reg;
    end
`endif

    // ------------------------------------------------------------------
    // Stage 1 register: captures the accepted input word
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_low_reg   <= '0;
            s1_fit_reg   <= 1'b0;
`ifdef IMM_NARROW_SATURATE_EN
            s1_neg_reg   <= 1'b0;
`endif
        end else if (s1_take) begin
            s1_valid_reg <= in_valid;
            if (in_xfer) begin
                s1_low_reg <= in_data[N-1:0];
                s1_fit_reg <= in_fit;
`ifdef IMM_NARROW_SATURATE_EN
                s1_neg_reg <= in_data[W-1];
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 register: holds the result until the consumer takes it
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg <= 1'b0;
            s2_data_reg  <= '0;
            s2_fit_reg   <= 1'b0;
        end else if (s2_take) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_data_reg <= narrow_next;
                s2_fit_reg  <= s1_fit_reg;
            end
        end
    end

    // ------------------------------------------------------------------
    // Overflow statistics: count delivered non-fitting results, clear wins
    // ------------------------------------------------------------------
    always_comb begin
        ovf_count_next  = ovf_count_reg;
        ovf_sticky_next = ovf_sticky_reg;
        if (clr_stats) begin
            ovf_count_next  = '0;
            ovf_sticky_next = 1'b0;
        end else if (out_xfer && !s2_fit_reg) begin
            ovf_sticky_next = 1'b1;
            if (ovf_count_reg != {CNT_W{1'b1}}) begin
                ovf_count_next = ovf_count_reg + CNT_W'(1);
            end
        end
    end

    // Statistics state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_count_reg  <= '0;
            ovf_sticky_reg <= 1'b0;
        end else begin
            ovf_count_reg  <= ovf_count_next;
            ovf_sticky_reg <= ovf_sticky_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_valid  = s2_valid_reg;
    assign out_data   = s2_data_reg;
    assign out_fit    = s2_fit_reg;
    assign ovf_count  = ovf_count_reg;
    assign ovf_sticky = ovf_sticky_reg;

endmodule

// File: tb/tb_imm_narrow.sv
// Directed testbench for imm_narrow (N=7, W=16). A second instance with a
// 2-bit overflow counter shares the same stimulus to exercise saturation.
module tb_imm_narrow;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  out_data;
    logic        out_fit;
    logic [7:0]  ovf_count;
    logic        ovf_sticky;
    logic        clr_stats;

    logic        in_ready2;
    logic        out_valid2;
    logic [6:0]  out_data2;
    logic        out_fit2;
    logic [1:0]  ovf_count2;
    logic        ovf_sticky2;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    always #5 clk = ~clk;

    imm_narrow #(.N(7), .W(16), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_fit    (out_fit),
        .ovf_count  (ovf_count),
        .ovf_sticky (ovf_sticky),
        .clr_stats  (clr_stats)
    );

    imm_narrow #(.N(7), .W(16), .CNT_W(2)) dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready2),
        .in_data    (in_data),
        .out_valid  (out_valid2),
        .out_ready  (out_ready),
        .out_data   (out_data2),
        .out_fit    (out_fit2),
        .ovf_count  (ovf_count2),
        .ovf_sticky (ovf_sticky2),
        .clr_stats  (clr_stats)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected values that differ between truncating and clamping builds.
`ifdef IMM_NARROW_SATURATE_EN
    localparam logic [6:0] EXP_250   = 7'b0111111;
    localparam logic [6:0] EXP_64    = 7'b0111111;
    localparam logic [6:0] EXP_M65   = 7'b1000000;
`else
    localparam logic [6:0] EXP_250   = 7'b1111010;
    localparam logic [6:0] EXP_64    = 7'b1000000;
    localparam logic [6:0] EXP_M65   = 7'b0111111;
`endif

    logic [15:0] bp_words [10];
    logic [15:0] sext;
    logic [6:0]  held_d;
    logic        held_v;
    logic        acc;
    logic        xfer;
    int          cyc;
    int          sent;
    int          recv;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        clr_stats = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        tick();

        // Reset state
        check("rst_out_valid",  out_valid,  0);
        check("rst_out_data",   out_data,   0);
        check("rst_out_fit",    out_fit,    0);
        check("rst_ovf_count",  ovf_count,  0);
        check("rst_ovf_sticky", ovf_sticky, 0);
        check("rst_in_ready",   in_ready,   1);

        // Fitting positive value, 2-cycle latency
        in_valid = 1'b1; in_data = 16'd50;
        tick();
        in_valid = 1'b0;
        check("fit50_not_yet", out_valid, 0);
        tick();
        check("fit50_valid", out_valid, 1);
        check("fit50_data",  out_data,  7'b0110010);
        check("fit50_fit",   out_fit,   1);
        tick();
        check("fit50_ovf",   ovf_count, 0);
        check("fit50_drain", out_valid, 0);

        // Negative fitting value and sign-extension round trip
        in_valid = 1'b1; in_data = 16'hFFFA;
        tick();
        in_valid = 1'b0;
        tick();
        check("neg6_data", out_data, 7'b1111010);
        check("neg6_fit",  out_fit,  1);
        sext = {{9{out_data[6]}}, out_data};
        check("neg6_sext", sext, 16'hFFFA);
        tick();

        // Positive overflow
        in_valid = 1'b1; in_data = 16'd250;
        tick();
        in_valid = 1'b0;
        tick();
        check("ovf250_data", out_data, EXP_250);
        check("ovf250_fit",  out_fit,  0);
        check("ovf250_cnt_before", ovf_count, 0);
        tick();
        check("ovf250_cnt",    ovf_count,  1);
        check("ovf250_sticky", ovf_sticky, 1);

        // Clear statistics while idle
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        check("clr_cnt",    ovf_count,  0);
        check("clr_sticky", ovf_sticky, 0);

        // Boundaries back to back: 63, 64, -64, -65
        in_valid = 1'b1; in_data = 16'd63;
        tick();
        in_data = 16'd64;
        tick();
        check("b63_data", out_data, 7'b0111111);
        check("b63_fit",  out_fit,  1);
        in_data = 16'hFFC0;
        tick();
        check("b64_data", out_data, EXP_64);
        check("b64_fit",  out_fit,  0);
        in_data = 16'hFFBF;
        tick();
        check("bm64_data", out_data, 7'b1000000);
        check("bm64_fit",  out_fit,  1);
        in_valid = 1'b0;
        tick();
        check("bm65_data", out_data, EXP_M65);
        check("bm65_fit",  out_fit,  0);
        tick();
        check("bnd_cnt",   ovf_count, 2);
        check("bnd_valid", out_valid, 0);

        // Backpressure: 10 words, out_ready low for the first 5 cycles
        for (int i = 0; i < 10; i++) bp_words[i] = 16'(i * 7 - 30);
        cyc = 0; sent = 0; recv = 0; held_v = 1'b0; held_d = '0;
        while (recv < 10 && cyc < 60) begin
            out_ready = (cyc >= 5);
            in_valid  = (sent < 10);
            in_data   = (sent < 10) ? bp_words[sent] : 16'h0;
            #1;
            if (cyc >= 2 && cyc < 5) begin
                check("bp_in_ready_low", in_ready, 0);
                check("bp_sent_two", sent, 2);
            end
            if (held_v) check("bp_hold_stable", out_data, held_d);
            acc  = in_valid & in_ready;
            xfer = out_valid & out_ready;
            if (xfer) check("bp_order", out_data, bp_words[recv][6:0]);
            held_v = out_valid & ~out_ready;
            held_d = out_data;
            tick();
            if (acc)  sent++;
            if (xfer) recv++;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_recv_all", recv, 10);
        check("bp_sent_all", sent, 10);
        tick();

        // Five overflows: the 2-bit counter saturates at 3
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        in_valid = 1'b1;
        in_data = 16'd1000;  tick();
        in_data = 16'hFC18;  tick();
        in_data = 16'd200;   tick();
        in_data = 16'd300;   tick();
        in_data = 16'hFF38;  tick();
        in_valid = 1'b0;
        repeat (3) tick();
        check("sat_cnt8",    ovf_count,   5);
        check("sat_cnt2",    ovf_count2,  3);
        check("sat_sticky2", ovf_sticky2, 1);

        // clr_stats coinciding with an overflow transfer: clear wins
        in_valid = 1'b1; in_data = 16'd250;
        tick();
        in_valid = 1'b0;
        tick();
        check("clrx_pending", out_valid, 1);
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        check("clrx_cnt",    ovf_count,  0);
        check("clrx_sticky", ovf_sticky, 0);
        check("clrx_cnt2",   ovf_count2, 0);
        check("clrx_valid",  out_valid,  0);

        // Reset with both stages full
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'd5;
        tick();
        in_data = 16'd6;
        tick();
        in_valid = 1'b0;
        #1;
        check("full_valid",   out_valid, 1);
        check("full_inready", in_ready,  0);
        #1 rst_n = 1'b0;
        #1;
        check("arst_valid",   out_valid, 0);
        check("arst_data",    out_data,  0);
        check("arst_inready", in_ready,  1);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_no_stale", out_valid, 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
